// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, port count, width defaults.
package alu_arb_pkg;
  localparam int N_REQ      = 2;
  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic             last_grant_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             gnt_idx_o
);

  // Pick the winner index, then expand to a one-hot grant if anyone asked.
  always_comb begin
    gnt_idx_o = (req_valid_i == 2'b11) ? ~last_grant_i : req_valid_i[1];
    gnt_o     = '0;
    if (|req_valid_i) gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two valid/ready requesters.
// One op in flight: IDLE (grant + operand capture) -> EXEC (ALU settles,
// result captured) -> RESP (hold until owner consumes).
// Optional statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
`ifdef ALU_ARB_STATS_EN
  ,parameter int CNT_W = CNT_W_DEF
`endif
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_in1,
  input  logic [N_REQ*DATA_W-1:0] req_in2,
  input  logic [N_REQ*CTRL_W-1:0] req_ctrl,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]       resp_result,
  output logic                    resp_zero,
  output logic [DATA_W-1:0]       alu_in1,
  output logic [DATA_W-1:0]       alu_in2,
  output logic [CTRL_W-1:0]       alu_control,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_zero,
  output logic                    busy
`ifdef ALU_ARB_STATS_EN
  ,output logic [CNT_W-1:0]       grant_cnt0
  ,output logic [CNT_W-1:0]       grant_cnt1
  ,output logic [CNT_W-1:0]       stall_cnt
`endif
);

  state_e             state_q;
  logic               last_q;
  logic               owner_q;
  logic [DATA_W-1:0]  in1_q, in2_q, res_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic               zero_q;
  logic [N_REQ-1:0]   rvalid_q;
  logic [N_REQ-1:0]   gnt;
  logic               gnt_idx;

  rr_arbiter2 u_rr (
    .req_valid_i  (req_valid),
    .last_grant_i (last_q),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx)
  );

  // Grants are only visible while idle; response backpressure never gates them.
  assign req_ready   = (state_q == IDLE) ? gnt : '0;
  assign busy        = (state_q != IDLE);
  assign resp_valid  = rvalid_q;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_control = ctrl_q;

  // Arbitration FSM with registered ALU operands and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      ctrl_q   <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      rvalid_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_ready) begin
          in1_q   <= gnt_idx ? req_in1[2*DATA_W-1:DATA_W] : req_in1[DATA_W-1:0];
          in2_q   <= gnt_idx ? req_in2[2*DATA_W-1:DATA_W] : req_in2[DATA_W-1:0];
          ctrl_q  <= gnt_idx ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
          owner_q <= gnt_idx;
          last_q  <= gnt_idx;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q    <= alu_result;
          zero_q   <= alu_zero;
          rvalid_q <= owner_q ? 2'b10 : 2'b01;
          state_q  <= RESP;
        end
        RESP: if (resp_ready[owner_q]) begin
          rvalid_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic stall;
  assign stall = |(req_valid & ~req_ready);

  // Saturating grant and stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (req_ready[0] && req_valid[0] && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req_ready[1] && req_valid[1] && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU stub.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [2*DW-1:0] req_in1, req_in2;
  logic [2*CW-1:0] req_ctrl;
  logic [DW-1:0] resp_result, alu_in1, alu_in2, alu_result;
  logic          resp_zero, alu_zero, busy;
  logic [CW-1:0] alu_control;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]   grant_cnt0, grant_cnt1, stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_ctrl(req_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    ,.grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
`endif
  );

  // ALU stub: AND/OR/ADD/SUB/XOR by control code.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0110: alu_result = alu_in1 - alu_in2;
      4'b1000: alu_result = alu_in1 ^ alu_in2;
      default: alu_result = alu_in1 + alu_in2;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  initial begin
    req_valid = '0; resp_ready = '0; req_in1 = '0; req_in2 = '0; req_ctrl = '0;
    do_reset();

    // Reset state
    chk("rst_rvalid", resp_valid, 2'b00);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_in1",    alu_in1, 0);
    chk("rst_ctrl",   alu_control, 0);
    chk("rst_result", resp_result, 0);

    // Port 0 single op: 23 + 42
    req_in1 = {32'd0, 32'd23}; req_in2 = {32'd0, 32'd42}; req_ctrl = {4'b0000, 4'b0010};
    req_valid = 2'b01; #1;
    chk("p0_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    chk("p0_in1",  alu_in1, 23);
    chk("p0_in2",  alu_in2, 42);
    chk("p0_ctrl", alu_control, 4'b0010);
    chk("p0_exec_rvalid", resp_valid, 2'b00);
    chk("p0_exec_busy",   busy, 1'b1);
    tick();
    chk("p0_rvalid", resp_valid, 2'b01);
    chk("p0_result", resp_result, 65);
    chk("p0_zero",   resp_zero, 1'b0);
    resp_ready = 2'b01; tick(); resp_ready = 2'b00;
    chk("p0_done_rvalid", resp_valid, 2'b00);
    chk("p0_done_busy",   busy, 1'b0);

    // Both ports from reset: grants alternate 0,1,0,1
    do_reset();
    req_in1 = {32'd12, 32'd12}; req_in2 = {32'd10, 32'd10}; req_ctrl = {4'b1000, 4'b0000};
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
      tick(); tick();
      chk("rr_rvalid", resp_valid, (k % 2) ? 2'b10 : 2'b01);
      chk("rr_result", resp_result, (k % 2) ? 6 : 8);
      tick();
    end
    req_valid = 2'b00; resp_ready = 2'b00;

    // Backpressure on port 1 (100-1), then zero-flag op on port 0 (42-42)
    req_in1 = {32'd100, 32'd42}; req_in2 = {32'd1, 32'd42}; req_ctrl = {4'b0110, 4'b0110};
    req_valid = 2'b10; #1;
    chk("bp_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b11; tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rvalid", resp_valid, 2'b10);
      chk("bp_result", resp_result, 99);
      chk("bp_busy",   busy, 1'b1);
      chk("bp_ready_hold", req_ready, 2'b00);
      tick();
    end
    resp_ready = 2'b01; tick();
    chk("bp_nonowner_ignored", resp_valid, 2'b10);
    resp_ready = 2'b10; tick(); resp_ready = 2'b00;
    chk("bp_cleared", resp_valid, 2'b00);
    chk("tie_after_p1", req_ready, 2'b01);
    tick(); req_valid = 2'b00; tick();
    chk("z_rvalid", resp_valid, 2'b01);
    chk("z_result", resp_result, 0);
    chk("z_flag",   resp_zero, 1'b1);
    resp_ready = 2'b01; tick(); resp_ready = 2'b00;

    // Reset during EXEC drops the op
    req_in1 = {32'd0, 32'd7}; req_in2 = {32'd0, 32'd9};
    req_valid = 2'b01; tick(); req_valid = 2'b00;
    chk("mid_exec_busy", busy, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rvalid", resp_valid, 2'b00);
    chk("mid_in1",    alu_in1, 0);
    chk("mid_ctrl",   alu_control, 0);
    chk("mid_busy",   busy, 1'b0);
    tick(); tick();
    chk("mid_no_resp", resp_valid, 2'b00);

`ifdef ALU_ARB_STATS_EN
    // 5 ops with both ports requesting: grants 0,1,0,1,0; every cycle stalls one port
    do_reset();
    chk("st_rst_stall", stall_cnt, 0);
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int c = 0; c < 15; c++) tick();
    req_valid = 2'b00; resp_ready = 2'b00;
    tick();
    chk("st_g0",    grant_cnt0, 3);
    chk("st_g1",    grant_cnt1, 2);
    chk("st_stall", stall_cnt, 15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
